// File: rtl/mem_store_ctrl_pkg.sv
// Shared types for the store path: data word, store size encoding and controller states.
package cpuDefine;

   typedef logic [31:0] DType;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10
   } st_size_e;

   typedef enum logic [1:0] {
      S_IDLE    = 2'b00,
      S_REQ     = 2'b01,
      S_WAIT_OK = 2'b10
   } state_e;

endpackage

// File: rtl/mem_store_ctrl_lane_gen.sv
// Combinational byte-lane generation for stores: aligned address, strobes, replicated data
// and misalignment flag (only reported when ALIGN_CHECK_EN is defined).
module store_lane_gen
   import cpuDefine::*;
(
   input  logic [1:0]  size_i,
   input  DType        addr_i,
   input  DType        data_i,
   output DType        addr_o,
   output logic [3:0]  wstrb_o,
   output DType        wdata_o,
   output logic        misaligned_o
);

   logic mis_s;
   logic align_chk_s;

`ifdef ALIGN_CHECK_EN
   assign align_chk_s = 1'b1;
`else
   assign align_chk_s = 1'b0;
`endif

   assign addr_o       = {addr_i[31:2], 2'b00};
   assign misaligned_o = align_chk_s & mis_s;

   // Lane select and data replication; the illegal size falls back to word lanes.
   always_comb begin
      wstrb_o = 4'b1111;
      wdata_o = data_i;
      mis_s   = 1'b1;
      case (size_i)
         SZ_B: begin
            wstrb_o = 4'b0001 << addr_i[1:0];
            wdata_o = {4{data_i[7:0]}};
            mis_s   = 1'b0;
         end
         SZ_H: begin
            wstrb_o = 4'b0011 << {addr_i[1], 1'b0};
            wdata_o = {2{data_i[15:0]}};
            mis_s   = addr_i[0];
         end
         SZ_W: begin
            wstrb_o = 4'b1111;
            wdata_o = data_i;
            mis_s   = |addr_i[1:0];
         end
         default: begin
            wstrb_o = 4'b1111;
            wdata_o = data_i;
            mis_s   = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/mem_store_ctrl.sv
// Store controller: accepts one pipeline store at a time and drives a req/addr_ok/data_ok SRAM port.
// Alignment exceptions (ale/ale_badv) are only raised when ALIGN_CHECK_EN is defined.
module mem_store_ctrl
   import cpuDefine::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        st_valid,
   output logic        st_ready,
   input  logic [1:0]  st_size,
   input  logic [31:0] st_addr,
   input  DType        st_data,
   input  logic        flush,
   output logic        data_sram_req,
   output logic        data_sram_wr,
   output logic [31:0] data_sram_addr,
   output logic [3:0]  data_sram_wstrb,
   output logic [31:0] data_sram_wdata,
   input  logic        data_sram_addr_ok,
   input  logic        data_sram_data_ok,
   output logic        st_done,
   output logic        ale,
   output logic [31:0] ale_badv,
   output logic        busy
);

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [3:0]  wstrb_q, wstrb_d;
   DType        wdata_q, wdata_d;
   logic        kill_q, kill_d;
   logic        ale_q, ale_d;
   logic [31:0] badv_q, badv_d;

   DType        lane_addr_s;
   logic [3:0]  lane_wstrb_s;
   DType        lane_wdata_s;
   logic        lane_mis_s;
   logic        accept_s;

   store_lane_gen u_lane (
      .size_i       (st_size),
      .addr_i       (st_addr),
      .data_i       (st_data),
      .addr_o       (lane_addr_s),
      .wstrb_o      (lane_wstrb_s),
      .wdata_o      (lane_wdata_s),
      .misaligned_o (lane_mis_s)
   );

   assign st_ready        = (state_q == S_IDLE) && !flush;
   assign accept_s        = st_valid && st_ready;
   assign data_sram_req   = (state_q == S_REQ);
   assign data_sram_wr    = 1'b1;
   assign data_sram_addr  = addr_q;
   assign data_sram_wstrb = wstrb_q;
   assign data_sram_wdata = wdata_q;
   assign ale             = ale_q;
   assign ale_badv        = badv_q;
   assign busy            = (state_q != S_IDLE);

   // Next-state logic; kill marks a store that was flushed after its address was taken.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wstrb_d = wstrb_q;
      wdata_d = wdata_q;
      kill_d  = kill_q;
      ale_d   = 1'b0;
      badv_d  = badv_q;
      st_done = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept_s && lane_mis_s) begin
               ale_d  = 1'b1;
               badv_d = st_addr;
            end else if (accept_s) begin
               state_d = S_REQ;
               addr_d  = lane_addr_s;
               wstrb_d = lane_wstrb_s;
               wdata_d = lane_wdata_s;
               kill_d  = 1'b0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_REQ: begin
            if (data_sram_addr_ok && data_sram_data_ok) begin
               state_d = S_IDLE;
               st_done = !flush;
            end else if (data_sram_addr_ok) begin
               state_d = S_WAIT_OK;
               kill_d  = flush;
            end else if (flush) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_REQ;
            end
         end
         S_WAIT_OK: begin
            if (data_sram_data_ok) begin
               state_d = S_IDLE;
               st_done = !(kill_q || flush);
            end else begin
               kill_d  = kill_q || flush;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         addr_q  <= 32'h0000_0000;
         wstrb_q <= 4'b0000;
         wdata_q <= 32'h0000_0000;
         kill_q  <= 1'b0;
         ale_q   <= 1'b0;
         badv_q  <= 32'h0000_0000;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wstrb_q <= wstrb_d;
         wdata_q <= wdata_d;
         kill_q  <= kill_d;
         ale_q   <= ale_d;
         badv_q  <= badv_d;
      end
   end

endmodule

// File: tb/tb_mem_store_ctrl.sv
// Directed bench for mem_store_ctrl: a transaction-level model checked every cycle plus literal expectations.
module tb_mem_store_ctrl;

   logic        clk = 1'b0;
   logic        rst_n, st_valid, st_ready, flush;
   logic [1:0]  st_size;
   logic [31:0] st_addr, st_data;
   logic        data_sram_req, data_sram_wr, data_sram_addr_ok, data_sram_data_ok;
   logic [31:0] data_sram_addr, data_sram_wdata, ale_badv;
   logic [3:0]  data_sram_wstrb;
   logic        st_done, ale, busy;

   int n_pass  = 0;
   int n_total = 0;

   bit          m_req, m_wait, m_cancel, m_ale, exp_done;
   logic [31:0] m_addr, m_data, m_badv;
   logic [3:0]  m_strb;

   always #5 clk = ~clk;

   mem_store_ctrl dut (
      .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(st_ready),
      .st_size(st_size), .st_addr(st_addr), .st_data(st_data), .flush(flush),
      .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
      .data_sram_addr(data_sram_addr), .data_sram_wstrb(data_sram_wstrb),
      .data_sram_wdata(data_sram_wdata), .data_sram_addr_ok(data_sram_addr_ok),
      .data_sram_data_ok(data_sram_data_ok), .st_done(st_done), .ale(ale),
      .ale_badv(ale_badv), .busy(busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   function automatic bit model_mis(input logic [1:0] sz, input logic [31:0] a);
`ifdef ALIGN_CHECK_EN
      return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [3:0] model_strb(input logic [1:0] sz, input logic [31:0] a);
      if (sz == 2'd0) return 4'(1 << (a % 4));
      else if (sz == 2'd1) return 4'(3 << (((a % 4) / 2) * 2));
      else return 4'd15;
   endfunction

   function automatic logic [31:0] model_data(input logic [1:0] sz, input logic [31:0] d);
      if (sz == 2'd0) return (d % 256) * 32'h0101_0101;
      else if (sz == 2'd1) return (d % 65536) * 32'h0001_0001;
      else return d;
   endfunction

   // Per-cycle compare against the transaction model, then advance the model with this cycle's inputs.
   always @(negedge clk) begin
      if (!rst_n) begin
         m_req = 0; m_wait = 0; m_cancel = 0; m_ale = 0;
         m_addr = 32'd0; m_data = 32'd0; m_badv = 32'd0; m_strb = 4'd0;
      end
      exp_done = rst_n && !flush && !m_cancel &&
                 ((m_req && data_sram_addr_ok && data_sram_data_ok) || (m_wait && data_sram_data_ok));
      chk("m_st_ready", 32'(st_ready), 32'(!m_req && !m_wait && !flush));
      chk("m_busy", 32'(busy), 32'(m_req || m_wait));
      chk("m_req", 32'(data_sram_req), 32'(m_req));
      chk("m_wr", 32'(data_sram_wr), 32'd1);
      chk("m_st_done", 32'(st_done), 32'(exp_done));
      chk("m_ale", 32'(ale), 32'(m_ale));
      chk("m_ale_badv", ale_badv, m_badv);
      if (m_req || !rst_n) begin
         chk("m_addr", data_sram_addr, m_addr);
         chk("m_wstrb", 32'(data_sram_wstrb), 32'(m_strb));
         chk("m_wdata", data_sram_wdata, m_data);
      end
      if (rst_n) begin
         m_ale = 0;
         if (m_req) begin
            if (data_sram_addr_ok) begin
               m_req = 0;
               if (!data_sram_data_ok) begin m_wait = 1; m_cancel = flush; end
            end else if (flush) m_req = 0;
         end else if (m_wait) begin
            if (data_sram_data_ok) m_wait = 0;
            else if (flush) m_cancel = 1;
         end else if (st_valid && !flush) begin
            if (model_mis(st_size, st_addr)) begin
               m_ale = 1; m_badv = st_addr;
            end else begin
               m_req = 1; m_cancel = 0;
               m_addr = st_addr - (st_addr % 4);
               m_strb = model_strb(st_size, st_addr);
               m_data = model_data(st_size, st_data);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic accept_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
      st_valid = 1'b1; st_size = sz; st_addr = a; st_data = d;
      tick();
      st_valid = 1'b0;
   endtask

   task automatic run_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d, input int dly);
      accept_store(sz, a, d);
      if (!model_mis(sz, a)) begin
         repeat (dly) tick();
         data_sram_addr_ok = 1'b1;
         tick();
         data_sram_addr_ok = 1'b0;
         data_sram_data_ok = 1'b1;
         tick();
         data_sram_data_ok = 1'b0;
      end else begin
         tick();
      end
   endtask

   logic [1:0]  v_sz [8] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd1};
   logic [31:0] v_a  [8] = '{32'h9000, 32'h9001, 32'h9002, 32'h9000, 32'h9003, 32'h9006, 32'h9008, 32'h900A};
   logic [31:0] v_d  [8] = '{32'h12, 32'h34, 32'h56, 32'hABCD, 32'hABCD, 32'hDEADBEEF, 32'h0BADF00D, 32'h5555AAAA};

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; st_valid = 1'b0; st_size = 2'd0; st_addr = 32'd0; st_data = 32'd0;
      flush = 1'b0; data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", 32'(st_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      tick();

      // byte store, addr_ok on cycle 2, data_ok on cycle 4
      accept_store(2'd0, 32'h1003, 32'h0000_00A5);
      @(negedge clk);
      chk("t1_addr", data_sram_addr, 32'h1000);
      chk("t1_wstrb", 32'(data_sram_wstrb), 32'h8);
      chk("t1_wdata", data_sram_wdata, 32'hA5A5_A5A5);
      tick(); data_sram_addr_ok = 1'b1;
      @(negedge clk); chk("t1_req_c2", 32'(data_sram_req), 32'd1);
      tick(); data_sram_addr_ok = 1'b0;
      @(negedge clk); chk("t1_wait_busy", 32'(busy), 32'd1); chk("t1_wait_req", 32'(data_sram_req), 32'd0);
      tick(); data_sram_data_ok = 1'b1;
      @(negedge clk); chk("t1_done", 32'(st_done), 32'd1);
      tick(); data_sram_data_ok = 1'b0;
      @(negedge clk); chk("t1_idle", 32'(busy), 32'd0);

      // half store, addr_ok and data_ok together
      accept_store(2'd1, 32'h2002, 32'h1234_BEEF);
      data_sram_addr_ok = 1'b1; data_sram_data_ok = 1'b1;
      @(negedge clk);
      chk("t2_wstrb", 32'(data_sram_wstrb), 32'hC);
      chk("t2_wdata", data_sram_wdata, 32'hBEEF_BEEF);
      chk("t2_done", 32'(st_done), 32'd1);
      tick(); data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
      @(negedge clk); chk("t2_idle", 32'(busy), 32'd0); chk("t2_ready", 32'(st_ready), 32'd1);

      // word store held five cycles without addr_ok
      accept_store(2'd2, 32'h3000, 32'hCAFE_F00D);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t3_req", 32'(data_sram_req), 32'd1);
         chk("t3_addr", data_sram_addr, 32'h3000);
         chk("t3_wstrb", 32'(data_sram_wstrb), 32'hF);
         chk("t3_wdata", data_sram_wdata, 32'hCAFE_F00D);
         tick();
      end
      data_sram_addr_ok = 1'b1; data_sram_data_ok = 1'b1;
      @(negedge clk); chk("t3_done", 32'(st_done), 32'd1);
      tick(); data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;

      // misaligned word
      accept_store(2'd2, 32'h4001, 32'h1122_3344);
`ifdef ALIGN_CHECK_EN
      @(negedge clk);
      chk("t4_ale", 32'(ale), 32'd1);
      chk("t4_badv", ale_badv, 32'h4001);
      chk("t4_noreq", 32'(data_sram_req), 32'd0);
      tick();
      @(negedge clk); chk("t4_ale_off", 32'(ale), 32'd0); chk("t4_noreq2", 32'(data_sram_req), 32'd0);
      tick();
`else
      @(negedge clk);
      chk("t4_req", 32'(data_sram_req), 32'd1);
      chk("t4_addr", data_sram_addr, 32'h4000);
      chk("t4_wstrb", 32'(data_sram_wstrb), 32'hF);
      chk("t4_ale", 32'(ale), 32'd0);
      tick(); data_sram_addr_ok = 1'b1; data_sram_data_ok = 1'b1;
      @(negedge clk); chk("t4_done", 32'(st_done), 32'd1);
      tick(); data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
`endif

      // flush in REQ before addr_ok
      accept_store(2'd2, 32'h6000, 32'h5);
      flush = 1'b1;
      @(negedge clk); chk("t5a_req", 32'(data_sram_req), 32'd1); chk("t5a_ready", 32'(st_ready), 32'd0);
      tick(); flush = 1'b0;
      @(negedge clk); chk("t5a_drop", 32'(data_sram_req), 32'd0); chk("t5a_idle", 32'(busy), 32'd0);
      tick();

      // flush in WAIT_OK: completion still awaited, st_done suppressed
      accept_store(2'd2, 32'h7000, 32'h6);
      data_sram_addr_ok = 1'b1;
      tick(); data_sram_addr_ok = 1'b0; flush = 1'b1;
      @(negedge clk); chk("t5b_busy", 32'(busy), 32'd1);
      tick(); flush = 1'b0;
      tick(); data_sram_data_ok = 1'b1;
      @(negedge clk); chk("t5b_nodone", 32'(st_done), 32'd0); chk("t5b_busy2", 32'(busy), 32'd1);
      tick(); data_sram_data_ok = 1'b0;
      @(negedge clk); chk("t5b_idle", 32'(busy), 32'd0);
      tick();

      // reset during WAIT_OK
      accept_store(2'd2, 32'h8000, 32'h77);
      data_sram_addr_ok = 1'b1;
      tick(); data_sram_addr_ok = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_req", 32'(data_sram_req), 32'd0);
      chk("t6_addr", data_sram_addr, 32'd0);
      chk("t6_wstrb", 32'(data_sram_wstrb), 32'd0);
      chk("t6_wdata", data_sram_wdata, 32'd0);
      tick(); rst_n = 1'b1; data_sram_data_ok = 1'b1;
      @(negedge clk); chk("t6_nodone", 32'(st_done), 32'd0); chk("t6_ready", 32'(st_ready), 32'd1);
      tick(); data_sram_data_ok = 1'b0;

      // table of mixed sizes/offsets checked by the model
      for (int i = 0; i < 8; i++) run_store(v_sz[i], v_a[i], v_d[i], i % 3);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
